// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: walks operand bits MSB-first,
// stopping at the first differing bit, and reports one-hot l/g/e with a done pulse.
module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             g,
    output logic             e
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_p0, b_p0, a_nxt, b_nxt;
    logic [IDX_W-1:0] idx_p0, idx_nxt;
    logic             l_nxt, g_nxt, e_nxt;
    logic             ai, bi;
    logic [2:0]       bit_res;

    // Returns {lt, gt, eq} for a single bit pair.
    function automatic logic [2:0] bit_cmp(input logic x, input logic y);
        bit_cmp = {~x & y, x & ~y, ~(x ^ y)};
    endfunction

    assign ai      = a_p0[idx_p0];
    assign bi      = b_p0[idx_p0];
    assign bit_res = bit_cmp(ai, bi);

    always_comb begin
        state_nxt = state;
        a_nxt     = a_p0;
        b_nxt     = b_p0;
        idx_nxt   = idx_p0;
        l_nxt     = l;
        g_nxt     = g;
        e_nxt     = e;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    idx_nxt   = IDX_W'(WIDTH - 1);
                    l_nxt     = 1'b0;
                    g_nxt     = 1'b0;
                    e_nxt     = 1'b0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_res[2]) begin
                    l_nxt     = 1'b1;
                    state_nxt = DONE;
                end else if (bit_res[1]) begin
                    g_nxt     = 1'b1;
                    state_nxt = DONE;
                end else if (idx_p0 == '0) begin
                    // All bits matched down to the LSB.
                    e_nxt     = 1'b1;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx_p0 - IDX_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // busy/done are registered copies derived from the next state so they
    // line up exactly with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_p0   <= '0;
            b_p0   <= '0;
            idx_p0 <= '0;
            l      <= 1'b0;
            g      <= 1'b0;
            e      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_p0   <= a_nxt;
            b_p0   <= b_nxt;
            idx_p0 <= idx_nxt;
            l      <= l_nxt;
            g      <= g_nxt;
            e      <= e_nxt;
            busy   <= (state_nxt != IDLE);
            done   <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed-table plus back-to-back random bench for serial_mag_comp (WIDTH=8).
module tb_serial_mag_comp;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, l, g, e;

    int checks = 0;
    int errors = 0;

    serial_mag_comp #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .l     (l),
        .g     (g),
        .e     (e)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic [2:0]       exp_lge;
        int               exp_k;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one compare from the current (idle) cycle; returns edges from
    // the accept edge to the edge that raised done, busy cycles seen, and
    // whether the cycle after DONE is idle. lat = -1 on timeout.
    task automatic run_cmp(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           output int lat, output int busy_cnt, output logic idle_after,
                           output logic cleared);
        lat      = -1;
        busy_cnt = 0;
        start = 1'b1;
        a     = va;
        b     = vb;
        tick();
        start   = 1'b0;
        a       = ~va;
        b       = ~vb;
        cleared = (l == 1'b0) && (g == 1'b0) && (e == 1'b0) && (busy == 1'b1);
        if (busy) busy_cnt++;
        for (int c = 1; c <= WIDTH + 5; c++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
        tick();
        idle_after = (busy == 1'b0) && (done == 1'b0);
    endtask

    function automatic int ref_k(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        ref_k = WIDTH;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (va[i] != vb[i]) begin
                ref_k = WIDTH - i;
                break;
            end
        end
    endfunction

    initial begin
        int         lat, bcnt, done_cnt;
        logic       idle_after, cleared, hold_ok, ever_done;
        logic [2:0] exp;
        logic [WIDTH-1:0] ra, rb;

        vecs[0] = '{8'h80, 8'h7F, 3'b010, 1};
        vecs[1] = '{8'h54, 8'h55, 3'b100, 8};
        vecs[2] = '{8'hA5, 8'hA5, 3'b001, 8};
        vecs[3] = '{8'h00, 8'hFF, 3'b100, 1};
        vecs[4] = '{8'hFF, 8'hFE, 3'b010, 8};
        vecs[5] = '{8'h10, 8'h20, 3'b100, 3};
        vecs[6] = '{8'h00, 8'h00, 3'b001, 8};
        vecs[7] = '{8'h0C, 8'h08, 3'b010, 6};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_lge", {l, g, e}, 3'b000);
        rst = 1'b0;
        tick();

        // Reset in the middle of a compare (0x01 vs 0x02 would need 7 edges).
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_lge", {l, g, e}, 3'b000);
        ever_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) ever_done = 1'b1;
        end
        check("midrst_no_done", ever_done, 0);

        foreach (vecs[i]) begin
            run_cmp(vecs[i].va, vecs[i].vb, lat, bcnt, idle_after, cleared);
            check($sformatf("vec%0d_lge", i), {l, g, e}, vecs[i].exp_lge);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_k);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_k + 1);
            check($sformatf("vec%0d_idle_after", i), idle_after, 1);
            check($sformatf("vec%0d_cleared", i), cleared, 1);
            if (i == 2) begin
                hold_ok = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    tick();
                    if ({l, g, e} !== 3'b001 || busy !== 1'b0) hold_ok = 1'b0;
                end
                check("equal_hold_5_idle", hold_ok, 1);
            end
        end

        // Start pulsed with new operands while busy must be ignored.
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h20;
        tick();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        done_cnt = 0;
        tick();
        start = 1'b0;
        if (done) done_cnt++;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done) done_cnt++;
        end
        check("ignored_start_lge", {l, g, e}, 3'b100);
        check("ignored_start_done_count", done_cnt, 1);

        // Back-to-back random compares.
        for (int n = 0; n < 200; n++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
            exp = (ra < rb) ? 3'b100 : (ra > rb) ? 3'b010 : 3'b001;
            run_cmp(ra, rb, lat, bcnt, idle_after, cleared);
            check($sformatf("rnd%0d_lge a=%0h b=%0h", n, ra, rb), {l, g, e}, exp);
            check($sformatf("rnd%0d_onehot", n), 32'(l) + 32'(g) + 32'(e), 1);
            check($sformatf("rnd%0d_latency", n), lat, ref_k(ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
